store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Posted-store queue between the MEM stage and the data SRAM port. Retired stores are queued and drained
//  to SRAM in idle port cycles. Loads check the queue the same cycle, forwarding bytes from queued stores.
//  A load that is only partly covered by queued stores raises a stall until those stores have drained.
// PARAMETERS
//  DEPTH   4   number of entries, power of two, >=2
//  AW      32  address width (entries compare word address [AW-1:2])
// PORTS
//  clk             in   1   system clock, rising edge
//  resetn          in   1   asynchronous active-low reset
//  st_valid        in   1   MEM stage presents a store this cycle
//  st_addr         in   AW  store byte address
//  st_wstrb        in   4   byte enables, already aligned to the lane
//  st_wdata        in   32  lane-aligned store data
//  st_ready        out  1   store accepted (not full); push = st_valid & st_ready
//  ld_valid        in   1   MEM stage presents a load this cycle
//  ld_addr         in   AW  load byte address
//  ld_bmask        in   4   bytes the load needs
//  fwd_hit         out  1   every byte in ld_bmask is supplied by queued stores
//  fwd_data        out  32  merged forwarded bytes (bytes not covered = 0)
//  ld_stall        out  1   partial coverage; pipeline holds the load
//  sb_empty        out  1   queue empty (for syscall/eret/uncached fences)
//  data_sram_en    out  1   drain write enable to SRAM
//  data_sram_wen   out  4   drain byte strobes
//  data_sram_addr  out  AW  drain address, word aligned ([1:0]=0)
//  data_sram_wdata out  32  drain data
// BEHAVIOUR
//  Reset: count=0, head=tail=0, all valid bits 0. sb_empty=1, st_ready=1. All other outputs 0.
//  Queue: circular, head = oldest. count is log2(DEPTH)+1 bits. head and tail wrap modulo DEPTH.
//  st_ready = (count!=DEPTH). A pop in the same cycle does not free a slot for that cycle's push.
//  Drain: pop = ~sb_empty & (~ld_valid | ld_stall). Data SRAM outputs are combinational from head.
//    data_sram_en=pop, so an entry leaves one cycle after its write is presented. A queued store takes at least 1 cycle to reach SRAM.
//  Push and pop in the same cycle: count is unchanged, and head and tail both advance.
//  Lookup (combinational, same cycle): only valid registered entries take part.
//    The store being pushed in this cycle is not visible to the lookup.
//    Per byte b: take the youngest valid entry with a word-address match and wstrb[b]=1, and supply its byte b.
//    cov = OR of supplied-byte flags & ld_bmask.
//    fwd_hit = ld_valid & (cov==ld_bmask) & |ld_bmask.
//    ld_stall = ld_valid & |cov & (cov!=ld_bmask).
//    With no match at all, the load reads SRAM normally (fwd_hit=0, ld_stall=0).
//  Stall liveness: while ld_stall=1 the queue drains every cycle. Coverage therefore falls monotonically to 0 and ld_stall releases.
//  ld_valid & st_valid in the same cycle is legal. The push completes and the lookup ignores the new entry.
//  Reset mid-drain: queued stores are discarded and the SRAM write presented in that cycle is killed (en=0 once resetn=0).
// CONFIGURATION
//  STBUF_MERGE_EN defined: a push merges into the tail-1 (youngest) entry instead of allocating a new one, when all of these hold:
//    the push hits the same word as that entry;
//    the entry is valid;
//    the entry is not popped this cycle.
//  Merge writes only the bytes where st_wstrb[b]=1 and ORs the strobes. count is unchanged, and st_ready may be 1 even when full.
//  STBUF_MERGE_EN undefined: every accepted store allocates a new entry, and st_ready = ~full exactly.
// STRUCTURE
//  Shared header/package stbuf_defs: entry record {valid, word_addr[AW-3:0], wstrb[3:0], wdata[31:0]}, DEPTH_LOG2, and the pointer width.
//  Sub-module stbuf_fwd_merge: per-byte youngest-match priority select over DEPTH entries, indexed relative to head.
//    Outputs cov[3:0] and data[31:0]. It is purely combinational. The top level owns the pointers, the count and the drain logic.
// TESTING
//  Reset: resetn=0 mid-drain -> data_sram_en=0 the same cycle. After release sb_empty=1, st_ready=1, fwd_hit=0.
//  Fill/drain: 4 stores, ld_valid=0 -> drained in order to 0x100,0x104,0x108,0x10C, one per cycle.
//    A 5th store while full with no pop -> st_ready=0.
//  Full hit: store 0x200 wstrb=F data=0xDEADBEEF, then load 0x200 bmask=F.
//    -> fwd_hit=1, fwd_data=0xDEADBEEF, data_sram_en=0 while the load occupies the port.
//  Youngest wins: stores 0x300 F 0x11111111 then 0x300 4'b0011 0x00002222, then load 0x300 bmask=F.
//    -> fwd_data=0x11112222, fwd_hit=1.
//  Partial stall: queue holds one store 0x400 4'b0001 0xAA, load 0x400 bmask=F held.
//    -> ld_stall=1 and the entry drains the same cycle. Next cycle ld_stall=0, fwd_hit=0.
//  Merge (STBUF_MERGE_EN): 0x500 4'b0001 0x11 then 0x500 4'b0010 0x2200, both back-to-back with ld_valid=1.
//    -> count=1, entry wstrb=0011, data=0x2211. Without the macro -> count=2.

Source files
------------

// File: rtl/stbuf_defs.sv
// Shared types and sizing for the store buffer: queue entry record and pointer widths.
package stbuf_defs;
  localparam int SB_DEPTH   = 4;
  localparam int SB_AW      = 32;
  localparam int DEPTH_LOG2 = $clog2(SB_DEPTH);
  localparam int PTR_W      = DEPTH_LOG2;
  localparam int CNT_W      = DEPTH_LOG2 + 1;

  typedef struct packed {
    logic              valid;
    logic [SB_AW-3:0]  word_addr;
    logic [3:0]        wstrb;
    logic [31:0]       wdata;
  } entry_t;
endpackage

// File: rtl/stbuf_fwd_merge.sv
// Per-byte load forwarding: for each byte lane, the youngest valid matching entry supplies the byte.
module stbuf_fwd_merge
  import stbuf_defs::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PW    = PTR_W
) (
  input  entry_t           ent [DEPTH],
  input  logic [PW-1:0]    head,
  input  logic [SB_AW-3:0] ld_waddr,
  input  logic [3:0]       ld_bmask,
  output logic [3:0]       cov,
  output logic [31:0]      data
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic       hit;
    logic [7:0] lane_byte;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
      hit       = 1'b0;
      lane_byte = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (ent[PW'(head + PW'(i))].valid &&
            ent[PW'(head + PW'(i))].word_addr == ld_waddr &&
            ent[PW'(head + PW'(i))].wstrb[gi]) begin
          hit       = 1'b1;
          lane_byte = ent[PW'(head + PW'(i))].wdata[8*gi +: 8];
        end
      end
    end

    assign cov[gi]          = hit & ld_bmask[gi];
    assign data[8*gi +: 8]  = cov[gi] ? lane_byte : 8'h00;
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-store queue between MEM and the data SRAM, with same-cycle load forwarding.
// Optional build macro STBUF_MERGE_EN: stores to the youngest entry's word merge instead of allocating.
module store_buffer
  import stbuf_defs::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [3:0]    st_wstrb,
  input  logic [31:0]   st_wdata,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [3:0]    ld_bmask,
  output logic          fwd_hit,
  output logic [31:0]   fwd_data,
  output logic          ld_stall,
  output logic          sb_empty,
  output logic          data_sram_en,
  output logic [3:0]    data_sram_wen,
  output logic [AW-1:0] data_sram_addr,
  output logic [31:0]   data_sram_wdata
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  entry_t        ent_reg [DEPTH];
  logic [PW-1:0] head_reg, tail_reg;
  logic [PW:0]   count_reg, count_next;

  logic       full, pop, push, alloc, merge_hit;
  logic [3:0] cov;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  stbuf_fwd_merge #(.DEPTH(DEPTH), .PW(PW)) u_fwd (
    .ent      (ent_reg),
    .head     (head_reg),
    .ld_waddr (ld_addr[AW-1:2]),
    .ld_bmask (ld_bmask),
    .cov      (cov),
    .data     (fwd_data)
  );

  assign sb_empty = (count_reg == '0);
  assign full     = (count_reg == FULL_CNT);
  assign fwd_hit  = ld_valid & (cov == ld_bmask) & (|ld_bmask);
  assign ld_stall = ld_valid & (|cov) & (cov != ld_bmask);
  // Drain only when the port is free; a stalled load frees it so coverage keeps shrinking.
  assign pop      = ~sb_empty & (~ld_valid | ld_stall);

`ifdef STBUF_MERGE_EN
  logic [PW-1:0] tail_m1;
  logic [31:0]   merged_wdata;
  assign tail_m1   = tail_reg - 1'b1;
  assign merge_hit = ent_reg[tail_m1].valid &
                     (ent_reg[tail_m1].word_addr == st_addr[AW-1:2]) &
                     ~(pop & (head_reg == tail_m1));
  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged_wdata[8*gi +: 8] = st_wstrb[gi] ? st_wdata[8*gi +: 8]
                                                  : ent_reg[tail_m1].wdata[8*gi +: 8];
  end
`else
  assign merge_hit = 1'b0;
`endif

  assign st_ready = ~full | merge_hit;
  assign push     = st_valid & st_ready;
  assign alloc    = push & ~merge_hit;

  always_comb begin
    count_next = count_reg;
    if (alloc && !pop)
      count_next = count_reg + 1'b1;
    else if (!alloc && pop)
      count_next = count_reg - 1'b1;
  end

  // Drain port presents the head entry; gated so an idle port shows all zeros.
  assign data_sram_en    = pop;
  assign data_sram_wen   = pop ? ent_reg[head_reg].wstrb : 4'h0;
  assign data_sram_addr  = pop ? {ent_reg[head_reg].word_addr, 2'b00} : '0;
  assign data_sram_wdata = pop ? ent_reg[head_reg].wdata : 32'h0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++)
        ent_reg[i] <= '0;
    end else begin
      if (pop) begin
        ent_reg[head_reg].valid <= 1'b0;
        head_reg                <= head_reg + 1'b1;
      end
      if (alloc) begin
        ent_reg[tail_reg].valid     <= 1'b1;
        ent_reg[tail_reg].word_addr <= st_addr[AW-1:2];
        ent_reg[tail_reg].wstrb     <= st_wstrb;
        ent_reg[tail_reg].wdata     <= st_wdata;
        tail_reg                    <= tail_reg + 1'b1;
      end
`ifdef STBUF_MERGE_EN
      if (push && merge_hit) begin
        ent_reg[tail_m1].wstrb <= ent_reg[tail_m1].wstrb | st_wstrb;
        ent_reg[tail_m1].wdata <= merged_wdata;
      end
`endif
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, fill/drain, forwarding, partial stall, merge and reset mid-drain.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        st_valid, ld_valid;
  logic [31:0] st_addr, ld_addr, st_wdata;
  logic [3:0]  st_wstrb, ld_bmask;
  logic        st_ready, fwd_hit, ld_stall, sb_empty, data_sram_en;
  logic [31:0] fwd_data, data_sram_addr, data_sram_wdata;
  logic [3:0]  data_sram_wen;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk             (clk),
    .resetn          (resetn),
    .st_valid        (st_valid),
    .st_addr         (st_addr),
    .st_wstrb        (st_wstrb),
    .st_wdata        (st_wdata),
    .st_ready        (st_ready),
    .ld_valid        (ld_valid),
    .ld_addr         (ld_addr),
    .ld_bmask        (ld_bmask),
    .fwd_hit         (fwd_hit),
    .fwd_data        (fwd_data),
    .ld_stall        (ld_stall),
    .sb_empty        (sb_empty),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  task automatic set_store(input logic v, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    st_valid = v; st_addr = a; st_wstrb = s; st_wdata = d;
  endtask

  task automatic set_load(input logic v, input logic [31:0] a, input logic [3:0] m);
    ld_valid = v; ld_addr = a; ld_bmask = m;
  endtask

  // Runs idle cycles until the queue reports empty; returns the writes seen.
  task automatic drain_all(output int writes, output logic [3:0] wen0, output logic [31:0] wdata0,
                           output logic [3:0] wen1, output logic [31:0] wdata1, output bit done);
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    set_load(1'b0, 32'h0, 4'h0);
    writes = 0; done = 1'b0; wen0 = 4'h0; wdata0 = 32'h0; wen1 = 4'h0; wdata1 = 32'h0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (sb_empty) begin done = 1'b1; break; end
      if (data_sram_en) begin
        if (writes == 0) begin wen0 = data_sram_wen; wdata0 = data_sram_wdata; end
        if (writes == 1) begin wen1 = data_sram_wen; wdata1 = data_sram_wdata; end
        writes++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    set_load(1'b0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    n_checks++; if (sb_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", sb_empty); end
    n_checks++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", st_ready); end
    n_checks++; if ({fwd_hit, ld_stall, data_sram_en} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {fwd_hit, ld_stall, data_sram_en}); end
    n_checks++; if ({data_sram_wen, data_sram_addr, data_sram_wdata, fwd_data} !== '0) begin n_fail++; $display("FAIL reset_data got %h/%h/%h/%h want 0", data_sram_wen, data_sram_addr, data_sram_wdata, fwd_data); end
    resetn = 1'b1;
    @(negedge clk);
    $display("reset: empty=%b ready=%b", sb_empty, st_ready);
  endtask

  task automatic test_fill_drain();
    for (int k = 0; k < 4; k++) begin
      set_store(1'b1, 32'h100 + 32'(4*k), 4'hF, 32'(k + 1));
      set_load(1'b1, 32'h900, 4'hF);
      #1;
      n_checks++; if (st_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d] got %b want 1", k, st_ready); end
      $display("fill: store addr=%h ready=%b", st_addr, st_ready);
      @(negedge clk);
    end
    set_store(1'b1, 32'h110, 4'hF, 32'h55);
    #1;
    n_checks++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", st_ready); end
    n_checks++; if (data_sram_en !== 1'b0) begin n_fail++; $display("FAIL full_no_drain got %b want 0", data_sram_en); end
    $display("fill: 5th store ready=%b", st_ready);
    @(negedge clk);
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    set_load(1'b0, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !== {1'b1, 4'hF, 32'h100 + 32'(4*k), 32'(k + 1)})
        begin n_fail++; $display("FAIL drain[%0d] got en=%b wen=%h addr=%h data=%h want en=1 wen=f addr=%h data=%h", k, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, 32'h100 + 32'(4*k), k + 1); end
      $display("drain: en=%b addr=%h data=%h", data_sram_en, data_sram_addr, data_sram_wdata);
      @(negedge clk);
    end
    #1;
    n_checks++; if ({sb_empty, data_sram_en} !== 2'b10) begin n_fail++; $display("FAIL drained_empty got empty=%b en=%b want 1/0", sb_empty, data_sram_en); end
  endtask

  task automatic test_full_hit();
    set_store(1'b1, 32'h200, 4'hF, 32'hDEADBEEF);
    set_load(1'b0, 32'h0, 4'h0);
    @(negedge clk);
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    set_load(1'b1, 32'h200, 4'hF);
    #1;
    n_checks++; if ({fwd_hit, ld_stall} !== 2'b10) begin n_fail++; $display("FAIL full_hit_flags got hit=%b stall=%b want 1/0", fwd_hit, ld_stall); end
    n_checks++; if (fwd_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL full_hit_data got %h want deadbeef", fwd_data); end
    n_checks++; if (data_sram_en !== 1'b0) begin n_fail++; $display("FAIL full_hit_port got en=%b want 0", data_sram_en); end
    $display("full_hit: hit=%b data=%h en=%b", fwd_hit, fwd_data, data_sram_en);
    @(negedge clk);
    set_load(1'b0, 32'h0, 4'h0);
    #1;
    n_checks++; if ({data_sram_en, data_sram_addr} !== {1'b1, 32'h200}) begin n_fail++; $display("FAIL full_hit_drain got en=%b addr=%h want 1/200", data_sram_en, data_sram_addr); end
    @(negedge clk);
  endtask

  task automatic test_youngest();
    int w; bit done; logic [3:0] s0, s1; logic [31:0] d0, d1;
    set_load(1'b1, 32'h900, 4'hF);
    set_store(1'b1, 32'h300, 4'hF, 32'h11111111);
    @(negedge clk);
    set_store(1'b1, 32'h300, 4'b0011, 32'h00002222);
    @(negedge clk);
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    set_load(1'b1, 32'h300, 4'hF);
    #1;
    n_checks++; if ({fwd_hit, fwd_data} !== {1'b1, 32'h11112222}) begin n_fail++; $display("FAIL youngest got hit=%b data=%h want 1/11112222", fwd_hit, fwd_data); end
    $display("youngest: hit=%b data=%h", fwd_hit, fwd_data);
    set_load(1'b1, 32'h300, 4'b1100);
    #1;
    n_checks++; if ({fwd_hit, fwd_data} !== {1'b1, 32'h11110000}) begin n_fail++; $display("FAIL youngest_upper got hit=%b data=%h want 1/11110000", fwd_hit, fwd_data); end
    @(negedge clk);
    drain_all(w, s0, d0, s1, d1, done);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL youngest_drain_timeout got %b want 1", done); end
  endtask

  task automatic test_partial_stall();
    set_store(1'b1, 32'h400, 4'b0001, 32'h000000AA);
    set_load(1'b1, 32'h900, 4'hF);
    @(negedge clk);
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    set_load(1'b1, 32'h400, 4'hF);
    #1;
    n_checks++; if ({ld_stall, fwd_hit} !== 2'b10) begin n_fail++; $display("FAIL partial_stall got stall=%b hit=%b want 1/0", ld_stall, fwd_hit); end
    n_checks++; if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !== {1'b1, 4'b0001, 32'h400, 32'h000000AA})
      begin n_fail++; $display("FAIL partial_drain got en=%b wen=%h addr=%h data=%h want 1/1/400/aa", data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata); end
    $display("partial: stall=%b en=%b addr=%h", ld_stall, data_sram_en, data_sram_addr);
    @(negedge clk);
    #1;
    n_checks++; if ({ld_stall, fwd_hit, sb_empty} !== 3'b001) begin n_fail++; $display("FAIL partial_release got stall=%b hit=%b empty=%b want 0/0/1", ld_stall, fwd_hit, sb_empty); end
    @(negedge clk);
  endtask

  task automatic test_merge();
    int w; bit done; logic [3:0] s0, s1; logic [31:0] d0, d1;
    set_load(1'b1, 32'h900, 4'hF);
    set_store(1'b1, 32'h500, 4'b0001, 32'h00000011);
    @(negedge clk);
    set_store(1'b1, 32'h500, 4'b0010, 32'h00002200);
    @(negedge clk);
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    set_load(1'b1, 32'h500, 4'b0011);
    #1;
    n_checks++; if ({fwd_hit, fwd_data} !== {1'b1, 32'h00002211}) begin n_fail++; $display("FAIL merge_fwd got hit=%b data=%h want 1/00002211", fwd_hit, fwd_data); end
    @(negedge clk);
    drain_all(w, s0, d0, s1, d1, done);
    $display("merge: writes=%0d wen0=%h data0=%h", w, s0, d0);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL merge_drain_timeout got %b want 1", done); end
`ifdef STBUF_MERGE_EN
    n_checks++; if (w !== 1) begin n_fail++; $display("FAIL merge_count got %0d want 1", w); end
    n_checks++; if ({s0, d0} !== {4'b0011, 32'h00002211}) begin n_fail++; $display("FAIL merge_entry got wen=%h data=%h want 3/00002211", s0, d0); end
`else
    n_checks++; if (w !== 2) begin n_fail++; $display("FAIL merge_count got %0d want 2", w); end
    n_checks++; if ({s0, d0, s1, d1} !== {4'b0001, 32'h00000011, 4'b0010, 32'h00002200})
      begin n_fail++; $display("FAIL merge_entries got %h/%h %h/%h want 1/00000011 2/00002200", s0, d0, s1, d1); end
`endif
  endtask

  task automatic test_back_to_back();
    set_store(1'b1, 32'h700, 4'hF, 32'h12345678);
    set_load(1'b1, 32'h700, 4'hF);
    #1;
    n_checks++; if ({fwd_hit, ld_stall, st_ready} !== 3'b001) begin n_fail++; $display("FAIL same_cycle got hit=%b stall=%b ready=%b want 0/0/1", fwd_hit, ld_stall, st_ready); end
    $display("same_cycle: hit=%b stall=%b", fwd_hit, ld_stall);
    @(negedge clk);
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    n_checks++; if ({fwd_hit, fwd_data} !== {1'b1, 32'h12345678}) begin n_fail++; $display("FAIL next_cycle_hit got hit=%b data=%h want 1/12345678", fwd_hit, fwd_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_drain();
    set_store(1'b1, 32'h800, 4'hF, 32'hCAFEF00D);
    set_load(1'b1, 32'h900, 4'hF);
    @(negedge clk);
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    set_load(1'b0, 32'h0, 4'h0);
    #1;
    n_checks++; if (data_sram_en !== 1'b1) begin n_fail++; $display("FAIL pre_reset_drain got %b want 1", data_sram_en); end
    resetn = 1'b0;
    #1;
    n_checks++; if ({data_sram_en, sb_empty, st_ready} !== 3'b011) begin n_fail++; $display("FAIL reset_kill got en=%b empty=%b ready=%b want 0/1/1", data_sram_en, sb_empty, st_ready); end
    $display("reset_mid_drain: en=%b empty=%b", data_sram_en, sb_empty);
    @(negedge clk);
    resetn = 1'b1;
    set_load(1'b1, 32'h800, 4'hF);
    #1;
    n_checks++; if ({fwd_hit, ld_stall, sb_empty} !== 3'b001) begin n_fail++; $display("FAIL post_reset got hit=%b stall=%b empty=%b want 0/0/1", fwd_hit, ld_stall, sb_empty); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_hit();
    test_youngest();
    test_partial_stall();
    test_merge();
    test_back_to_back();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
